// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and state encodings for the interconnect and its
// built-in default slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  typedef enum logic [1:0] {
    DSEL_NONE = 2'd0,
    DSEL_SLV  = 2'd1,
    DSEL_DEF  = 2'd2
  } dsel_kind_t;

endpackage

// File: rtl/ahb_interconnect_if.sv
// Bus bundle between the AHB master, the interconnect and its slaves.
// The slave modport is the interconnect's view.
interface ahb_interconnect_if #(
  parameter int DW   = 8,
  parameter int AW   = 11,
  parameter int NSLV = 2
) ();

  logic [AW-1:0]      haddr;
  logic [1:0]         htrans;
  logic [NSLV-1:0]    hsel;
  logic               hready;
  logic               hresp;
  logic [DW-1:0]      hrdata;
  logic [NSLV-1:0]    hreadyout_s;
  logic [NSLV-1:0]    hresp_s;
  logic [NSLV*DW-1:0] hrdata_s;

  modport slave (
    input  haddr, htrans, hreadyout_s, hresp_s, hrdata_s,
    output hsel, hready, hresp, hrdata
  );

  modport master (
    output haddr, htrans, hreadyout_s, hresp_s, hrdata_s,
    input  hsel, hready, hresp, hrdata
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response and a
// saturating decode-error counter.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            hready,
  input  logic            err_req,
  output logic            ds_ready,
  output logic            ds_resp,
  output logic [ERRW-1:0] err_count
);

  ds_state_t state, state_next;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= DS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ERR1 stalls the master, ERR2 completes the error and may accept a new one
  always_comb begin
    state_next = state;
    ds_ready   = 1'b1;
    ds_resp    = HRESP_OKAY;
    case (state)
      DS_IDLE: begin
        if (hready && err_req) state_next = DS_ERR1;
      end
      DS_ERR1: begin
        ds_ready   = 1'b0;
        ds_resp    = HRESP_ERROR;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp    = HRESP_ERROR;
        state_next = (hready && err_req) ? DS_ERR1 : DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_count <= '0;
    end else if (state_next == DS_ERR1 && err_count != {ERRW{1'b1}}) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decoder, data-phase aligned
// response multiplexer and built-in default slave for NSLV slaves.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 11,
  parameter int NSLV = 2,
  parameter int IDXW = 1,
  parameter int ERRW = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  ahb_interconnect_if.slave bus,
  output logic [ERRW-1:0]   err_count
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic [IDXW-1:0] idx;
  logic            mapped;
  logic            active;
  logic            ds_ready;
  logic            ds_resp;
  dsel_kind_t      dsel_kind;
  logic [SW-1:0]   dsel_slv;

  assign idx    = bus.haddr[AW-1 -: IDXW];
  assign mapped = int'(idx) < NSLV;

  always_comb begin
    bus.hsel = '0;
    for (int k = 0; k < NSLV; k++) bus.hsel[k] = (int'(idx) == k);
  end

  always_comb begin
    active = 1'b0;
    case (bus.htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
  end

  // Data-phase owner only advances when the current data phase completes
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel_kind <= DSEL_NONE;
      dsel_slv  <= '0;
    end else if (bus.hready) begin
      if (!active) begin
        dsel_kind <= DSEL_NONE;
      end else if (mapped) begin
        dsel_kind <= DSEL_SLV;
        dsel_slv  <= SW'(idx);
      end else begin
        dsel_kind <= DSEL_DEF;
      end
    end
  end

  always_comb begin
    bus.hready = 1'b1;
    bus.hresp  = HRESP_OKAY;
    bus.hrdata = '0;
    case (dsel_kind)
      DSEL_SLV: begin
        bus.hready = bus.hreadyout_s[dsel_slv];
        bus.hresp  = bus.hresp_s[dsel_slv];
        bus.hrdata = bus.hrdata_s[int'(dsel_slv)*DW +: DW];
      end
      DSEL_DEF: begin
        bus.hready = ds_ready;
        bus.hresp  = ds_resp;
      end
      default: ;
    endcase
  end

  ahb_default_slave #(.ERRW(ERRW)) u_default_slave (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hready    (bus.hready),
    .err_req   (active && !mapped),
    .ds_ready  (ds_ready),
    .ds_resp   (ds_resp),
    .err_count (err_count)
  );

endmodule
